hex_scroll_engine: RTL and testbench

//  Parametrised marquee engine for N 7-segment digits with a loadable RAM message buffer.

---
 rtl/hex_scroll_engine.sv | 207 ++++++++++++++++++++
 tb/tb_hex_scroll_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : hex_scroll_engine
// Brief    : N-digit 7-segment marquee with a loadable message RAM, prescaled
//            stepping, direction/rate/pause control and a load handshake.
//            Optional ping-pong scrolling when SCROLL_BOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hex_scroll_engine #(
  parameter int N_DIGITS = 6,
  parameter int MAX_LEN  = 16,
  parameter int SLOW_DIV = 20000000,
  parameter int FAST_DIV = 9000000,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  dir,
  input  logic                  fast,
  input  logic                  pause,
  input  logic                  mode,
  input  logic                  load_start,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [6:0]            wr_data,
  input  logic                  load_done,
  input  logic [AW:0]           load_len,
  output logic                  wr_ready,
  output logic [7*N_DIGITS-1:0] hex_out,
  output logic [AW-1:0]         pos,
  output logic                  step
);

  localparam int c_maxdiv = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int c_cw     = $clog2(c_maxdiv + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_cw-1:0]   r_cnt;
  logic [AW-1:0]     r_pos;
  logic [AW:0]       r_len;
  logic              r_step;
  logic [6:0]        r_buf [MAX_LEN];

  logic [c_cw-1:0]   w_top;
  logic              w_tick;
  logic              w_addr_ok;
  logic [AW:0]       w_len_m1;
  logic [AW:0]       w_len_clamped;
  logic [AW-1:0]     w_pos_wrap;
  logic [AW-1:0]     w_pos_next_tick;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (load_start) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:   if (load_done) w_state_next = ST_RUN;
        ST_RUN:    if (pause)     w_state_next = ST_PAUSED;
        ST_PAUSED: if (!pause)    w_state_next = ST_RUN;
        default:                  w_state_next = ST_RUN;
      endcase
    end
  end

  assign wr_ready = (r_state == ST_LOAD);

  // ---------------------------------------------------------------- prescaler / step
  assign w_top  = fast ? c_cw'(FAST_DIV - 1) : c_cw'(SLOW_DIV - 1);
  assign w_tick = (r_state == ST_RUN) && !load_start && (r_cnt == w_top);

  assign w_len_m1   = r_len - 1'b1;
  assign w_pos_wrap = dir ? (({1'b0, r_pos} == w_len_m1) ? '0 : r_pos + AW'(1))
                          : ((r_pos == '0) ? w_len_m1[AW-1:0] : r_pos - AW'(1));

  always_comb begin
    w_len_clamped = load_len;
    if (load_len == '0) begin
      w_len_clamped = (AW+1)'(1);
    end else if (int'(load_len) > MAX_LEN) begin
      w_len_clamped = (AW+1)'(MAX_LEN);
    end
  end

`ifdef SCROLL_BOUNCE_EN
  logic r_bdir;
  logic r_mode_q;
  logic w_bdir;
  logic w_bdir_next;
  int   w_limit;

  // Direction register is seeded from dir on the cycle bounce mode is entered.
  assign w_bdir  = (mode && !r_mode_q) ? dir : r_bdir;
  assign w_limit = int'(r_len) - N_DIGITS;

  always_comb begin
    w_pos_next_tick = w_pos_wrap;
    w_bdir_next     = w_bdir;
    if (mode) begin
      if (int'(r_len) <= N_DIGITS) begin
        w_pos_next_tick = '0;
      end else if (w_bdir) begin
        if (int'(r_pos) >= w_limit) begin
          w_pos_next_tick = r_pos;
          w_bdir_next     = 1'b0;
        end else begin
          w_pos_next_tick = r_pos + AW'(1);
        end
      end else begin
        if (r_pos == '0) begin
          w_pos_next_tick = r_pos;
          w_bdir_next     = 1'b1;
        end else begin
          w_pos_next_tick = r_pos - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_bdir   <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_mode_q <= mode;
      r_bdir   <= w_tick ? w_bdir_next : w_bdir;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode   = mode;
  assign w_pos_next_tick = w_pos_wrap;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_len  <= (AW+1)'(MAX_LEN);
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick;
      if (w_state_next == ST_LOAD) begin
        r_cnt <= '0;
        r_pos <= '0;
      end else if (r_state == ST_RUN) begin
        // A rate change can leave the count above the new top; restart quietly.
        if (w_tick || (r_cnt > w_top)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cw'(1);
        end
        if (w_tick) begin
          r_pos <= w_pos_next_tick;
        end
      end
      if ((r_state == ST_LOAD) && load_done && !load_start) begin
        r_len <= w_len_clamped;
      end
    end
  end

  // ---------------------------------------------------------------- message buffer
  if (MAX_LEN == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = (int'(wr_addr) < MAX_LEN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_buf[i] <= 7'h7F;
      end
    end else if (wr_ready && wr_en && w_addr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------- display window
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [AW-1:0] w_idx;
    assign w_idx = AW'((int'(r_pos) + k) % int'(r_len));
    assign hex_out[7*(N_DIGITS-k)-1 -: 7] = (r_state == ST_LOAD) ? 7'h7F : r_buf[w_idx];
  end

  assign pos  = r_pos;
  assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_scroll_engine
// Brief    : Self-checking bench for hex_scroll_engine against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_engine;

  localparam int N  = 6;
  localparam int ML = 8;
  localparam int SD = 4;
  localparam int FD = 2;

  localparam logic [6:0] G_S  = 7'h12;
  localparam logic [6:0] G_C  = 7'h46;
  localparam logic [6:0] G_R  = 7'h2F;
  localparam logic [6:0] G_O  = 7'h40;
  localparam logic [6:0] G_L  = 7'h47;
  localparam logic [6:0] G_BL = 7'h7F;

  localparam int MS_RUN = 0, MS_PAUSE = 1, MS_LOAD = 2;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1, dir = 1'b1, fast = 1'b0, pause = 1'b0, mode = 1'b0;
  logic        load_start = 1'b0, wr_en = 1'b0, load_done = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [6:0]  wr_data = '0;
  logic [3:0]  load_len = '0;
  logic        wr_ready, step;
  logic [41:0] hex_out;
  logic [2:0]  pos;

  int n_vec = 0;
  int n_err = 0;

  int         m_state, m_cnt, m_pos, m_len;
  bit         m_step;
  logic [6:0] m_buf [ML];
  logic [6:0] msg [7];

  hex_scroll_engine #(.N_DIGITS(N), .MAX_LEN(ML), .SLOW_DIV(SD), .FAST_DIV(FD)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .dir(dir), .fast(fast), .pause(pause),
    .mode(mode), .load_start(load_start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .load_done(load_done), .load_len(load_len),
    .wr_ready(wr_ready), .hex_out(hex_out), .pos(pos), .step(step)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [41:0] exp_hex();
    logic [41:0] r;
    r = '1;
    if (m_state != MS_LOAD)
      for (int k = 0; k < N; k++) r[7*(N-k)-1 -: 7] = m_buf[(m_pos + k) % m_len];
    return r;
  endfunction

  // Advance the reference model by one clock using the current inputs.
  task automatic cyc();
    int ns, nc, np, nl, top;
    bit nst;
    ns = m_state; nc = m_cnt; np = m_pos; nl = m_len; nst = 0;
    if (RESET) begin
      ns = MS_RUN; nc = 0; np = 0; nl = ML;
      for (int i = 0; i < ML; i++) m_buf[i] = G_BL;
    end else begin
      if (m_state == MS_LOAD && wr_en) m_buf[wr_addr] = wr_data;
      if (load_start) ns = MS_LOAD;
      else if (m_state == MS_LOAD && load_done) begin
        ns = MS_RUN;
        nl = (load_len == 0) ? 1 : ((int'(load_len) > ML) ? ML : int'(load_len));
      end
      else if (m_state == MS_RUN && pause) ns = MS_PAUSE;
      else if (m_state == MS_PAUSE && !pause) ns = MS_RUN;
      if (ns == MS_LOAD) begin
        nc = 0; np = 0;
      end else if (m_state == MS_RUN) begin
        top = (fast ? FD : SD) - 1;
        if (m_cnt > top) nc = 0;
        else if (m_cnt == top) begin
          nc = 0; nst = 1;
          np = dir ? (m_pos + 1) % m_len : (m_pos + m_len - 1) % m_len;
        end else nc = m_cnt + 1;
      end
    end
    @(posedge CLOCK_50);
    #1;
    m_state = ns; m_cnt = nc; m_pos = np; m_len = nl; m_step = nst;
  endtask

  task automatic reload(input logic [3:0] len);
    load_start = 1'b1; cyc(); load_start = 1'b0;
    load_done = 1'b1; load_len = len; cyc(); load_done = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) cyc();
    n_vec++; if (hex_out !== '1) begin n_err++; $display("FAIL reset_hex: got %h want all ones", hex_out); end
    n_vec++; if (pos !== 3'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b want 0", step); end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++; if (step !== (i == 3)) begin n_err++; $display("FAIL first_step c%0d: got %b want %b", i, step, (i == 3)); end
    end
    n_vec++; if (pos !== 3'd1) begin n_err++; $display("FAIL first_step_pos: got %0d want 1", pos); end
  endtask

  task automatic test_load_window();
    int got;
    dir = 1'b1;
    load_start = 1'b1; cyc(); load_start = 1'b0;
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL load_wr_ready: got %b want 1", wr_ready); end
    n_vec++; if (hex_out !== '1) begin n_err++; $display("FAIL load_blank: got %h want all ones", hex_out); end
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = msg[i]; cyc();
    end
    wr_en = 1'b0;
    load_done = 1'b1; load_len = 4'd7; cyc(); load_done = 1'b0;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL done_wr_ready: got %b want 0", wr_ready); end
    n_vec++; if (hex_out !== {G_S, G_C, G_R, G_O, G_L, G_L}) begin
      n_err++; $display("FAIL window0: got %h want %h", hex_out, {G_S, G_C, G_R, G_O, G_L, G_L}); end
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin cyc(); if (step) got = 1; end
    n_vec++; if (got != 1) begin n_err++; $display("FAIL window_step_timeout: got none want step"); end
    n_vec++; if (hex_out !== {G_C, G_R, G_O, G_L, G_L, G_BL}) begin
      n_err++; $display("FAIL window1: got %h want %h", hex_out, {G_C, G_R, G_O, G_L, G_L, G_BL}); end
  endtask

  task automatic test_scroll(input logic f, input int ncyc, input int spacing);
    int last, wraps;
    fast = f; dir = 1'b1; last = -1; wraps = 0;
    for (int i = 0; i < ncyc; i++) begin
      logic [2:0] prev;
      prev = pos;
      cyc();
      n_vec++; if (pos !== 3'(m_pos)) begin n_err++; $display("FAIL scroll_pos: got %0d want %0d", pos, m_pos); end
      n_vec++; if (step !== m_step) begin n_err++; $display("FAIL scroll_step: got %b want %b", step, m_step); end
      n_vec++; if (hex_out !== exp_hex()) begin n_err++; $display("FAIL scroll_hex: got %h want %h", hex_out, exp_hex()); end
      if (step) begin
        if (last >= 0 && i > 3) begin
          n_vec++; if (i - last != spacing) begin n_err++; $display("FAIL step_spacing: got %0d want %0d", i - last, spacing); end
        end
        if (prev == 3'd6 && pos == 3'd0) wraps++;
        last = i;
      end
    end
    n_vec++; if (wraps < 1) begin n_err++; $display("FAIL scroll_wrap: got %0d wraps want >=1", wraps); end
    fast = 1'b0;
  endtask

  task automatic test_dir_right();
    int got;
    reload(4'd7);
    dir = 1'b0; got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin cyc(); if (step) got = 1; end
    n_vec++; if (got != 1) begin n_err++; $display("FAIL dir_right_timeout: got none want step"); end
    n_vec++; if (pos !== 3'd6) begin n_err++; $display("FAIL dir_right_pos: got %0d want 6", pos); end
    dir = 1'b1;
  endtask

  task automatic test_pause();
    logic [2:0]  p0;
    logic [41:0] h0;
    repeat (2) cyc();
    pause = 1'b1; cyc();
    p0 = pos; h0 = hex_out;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_vec++; if (pos !== p0 || hex_out !== h0 || step !== 1'b0) begin
        n_err++; $display("FAIL pause_hold: pos %0d hex %h step %b want pos %0d hex %h step 0", pos, hex_out, step, p0, h0); end
    end
    pause = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_vec++; if (pos !== 3'(m_pos) || step !== m_step) begin
        n_err++; $display("FAIL pause_resume: pos %0d step %b want %0d %b", pos, step, m_pos, m_step); end
    end
  endtask

  task automatic test_wr_outside_load();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 7'h00;
      cyc();
      n_vec++; if (hex_out !== exp_hex()) begin n_err++; $display("FAIL wr_in_run: got %h want %h", hex_out, exp_hex()); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_len_clamp();
    int seen7;
    reload(4'd0);
    n_vec++; if (hex_out !== {6{G_S}}) begin n_err++; $display("FAIL len1_hex: got %h want %h", hex_out, {6{G_S}}); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_vec++; if (pos !== 3'd0 || step !== m_step) begin
        n_err++; $display("FAIL len1_pos: pos %0d step %b want 0 %b", pos, step, m_step); end
    end
    reload(4'd12);
    seen7 = 0;
    for (int i = 0; i < 36; i++) begin
      cyc();
      if (pos == 3'd7) seen7 = 1;
      n_vec++; if (pos !== 3'(m_pos) || hex_out !== exp_hex()) begin
        n_err++; $display("FAIL len8: pos %0d hex %h want %0d %h", pos, hex_out, m_pos, exp_hex()); end
    end
    n_vec++; if (seen7 != 1) begin n_err++; $display("FAIL len8_reach7: got %0d want 1", seen7); end
  endtask

  task automatic test_start_done_same();
    load_start = 1'b1; load_done = 1'b1; load_len = 4'd3; cyc();
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL same_from_run: got %b want 1", wr_ready); end
    cyc();
    n_vec++; if (wr_ready !== 1'b1 || hex_out !== '1) begin
      n_err++; $display("FAIL same_in_load: wr_ready %b hex %h want 1 all ones", wr_ready, hex_out); end
    load_start = 1'b0; load_len = 4'd7; cyc(); load_done = 1'b0;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL same_exit: got %b want 0", wr_ready); end
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_vec++; if (pos !== 3'(m_pos)) begin n_err++; $display("FAIL same_len: pos %0d want %0d", pos, m_pos); end
    end
  endtask

`ifdef SCROLL_BOUNCE_EN
  task automatic test_bounce();
    int exp_seq [7] = '{1, 2, 2, 1, 0, 0, 1};
    int k;
    dir = 1'b1; mode = 1'b1;
    reload(4'd8);
    k = 0;
    for (int i = 0; i < 60 && k < 7; i++) begin
      @(posedge CLOCK_50); #1;
      if (step) begin
        n_vec++; if (pos !== 3'(exp_seq[k])) begin n_err++; $display("FAIL bounce_seq%0d: got %0d want %0d", k, pos, exp_seq[k]); end
        k++;
      end
    end
    n_vec++; if (k != 7) begin n_err++; $display("FAIL bounce_timeout: got %0d steps want 7", k); end
    reload(4'd5);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK_50); #1;
      n_vec++; if (pos !== 3'd0) begin n_err++; $display("FAIL bounce_short: got %0d want 0", pos); end
    end
    mode = 1'b0;
    reload(4'd7);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET      = ($urandom_range(0, 299) == 0);
      dir        = $urandom_range(0, 7) != 0 ? dir : ~dir;
      if ($urandom_range(0, 19) == 0) fast = ~fast;
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      load_start = ($urandom_range(0, 39) == 0);
      load_done  = ($urandom_range(0, 5) == 0);
      load_len   = 4'($urandom_range(0, 15));
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 7'($urandom_range(0, 127));
      cyc();
      n_vec++; if (pos !== 3'(m_pos) || step !== m_step || wr_ready !== (m_state == MS_LOAD) || hex_out !== exp_hex()) begin
        n_err++;
        $display("FAIL random c%0d: pos %0d step %b rdy %b hex %h want %0d %b %b %h",
                 i, pos, step, wr_ready, hex_out, m_pos, m_step, (m_state == MS_LOAD), exp_hex());
      end
    end
    RESET = 1'b0; load_start = 1'b0; load_done = 1'b0; wr_en = 1'b0; pause = 1'b0;
  endtask

  initial begin
    msg[0] = G_S; msg[1] = G_C; msg[2] = G_R; msg[3] = G_O;
    msg[4] = G_L; msg[5] = G_L; msg[6] = G_BL;
    test_reset();
    test_load_window();
    test_scroll(1'b0, 32, 4);
    test_scroll(1'b1, 20, 2);
    test_dir_right();
    test_pause();
    test_wr_outside_load();
    test_len_clamp();
    test_start_done_same();
`ifdef SCROLL_BOUNCE_EN
    test_bounce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
